// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types and constants for the 4x4 keypad scanner
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD
  } state_e;

  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int CODE_W = 4;

  localparam logic [ROWS-1:0] ROW_IDLE = 4'b1111;

endpackage

// File: rtl/keypad_tick_gen.sv
// rtl/keypad_tick_gen.sv - scan tick divider, one-cycle tick when the counter sits at SCAN_DIV-1
module keypad_tick_gen #(
  parameter int SCAN_DIV = 50000
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == LAST);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad row scanner with debounce and single-key rollover
// Optional auto-repeat of key_valid while a key is held is enabled by defining KEY_REPEAT_EN.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_TICKS = 8,
  parameter int REPEAT_TICKS   = 25
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  keypad_col,
  output logic [3:0]  keypad_row,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_held
);

  localparam int RW = $clog2(ROWS);
  localparam int KW = $clog2(COLS);
  localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_TICKS);
`ifdef KEY_REPEAT_EN
  localparam int PW = $clog2(REPEAT_TICKS + 1);
  localparam logic [PW-1:0] REP_LAST = PW'(REPEAT_TICKS);
`endif

  logic              tick;
  logic [COLS-1:0]   sync1_q, sync2_q;
  state_e            state_q, state_d;
  logic [RW-1:0]     row_q, row_d;
  logic [CODE_W-1:0] cand_q, cand_d;
  logic [DW-1:0]     cnt_q, cnt_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              valid_q, valid_d;
  logic              held_q, held_d;
`ifdef KEY_REPEAT_EN
  logic [PW-1:0]     rep_q, rep_d;
`endif

  logic              key_present;
  logic [KW-1:0]     col_idx;
  logic [CODE_W-1:0] sample_code;
  logic              accept;

  keypad_tick_gen #(
    .SCAN_DIV (SCAN_DIV)
  ) u_tick_gen (
    .clock (clock),
    .reset (reset),
    .tick  (tick)
  );

  // Columns are asynchronous; only sync2_q is ever looked at.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= keypad_col;
      sync2_q <= sync1_q;
    end
  end

  // Lowest pressed column wins.
  always_comb begin
    key_present = ~&sync2_q;
    col_idx     = '0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (!sync2_q[c]) col_idx = KW'(c);
    end
    sample_code = {row_q, col_idx};
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    valid_d = 1'b0;
    held_d  = held_q;
    accept  = 1'b0;
`ifdef KEY_REPEAT_EN
    rep_d   = rep_q;
`endif

    if (tick) begin
      unique case (state_q)
        SCAN: begin
          if (!key_present) begin
            row_d = row_q + 1'b1;
          end else begin
            cand_d = sample_code;
            cnt_d  = DW'(1);
            if (DEB_LAST == DW'(1)) accept = 1'b1;
            else state_d = DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (key_present && (sample_code == cand_q)) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q + 1'b1 == DEB_LAST) accept = 1'b1;
          end else begin
            state_d = SCAN;
          end
        end
        HELD: begin
`ifdef KEY_REPEAT_EN
          if (rep_q + 1'b1 == REP_LAST) begin
            valid_d = 1'b1;
            rep_d   = '0;
          end else begin
            rep_d = rep_q + 1'b1;
          end
`endif
          // Any key at all, even a different one on the frozen row, restarts release debounce.
          if (key_present) begin
            cnt_d = '0;
          end else if (cnt_q + 1'b1 == DEB_LAST) begin
            cnt_d   = '0;
            held_d  = 1'b0;
            state_d = SCAN;
            row_d   = row_q + 1'b1;
`ifdef KEY_REPEAT_EN
            rep_d   = '0;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = SCAN;
      endcase
    end

    if (accept) begin
      code_d  = sample_code;
      valid_d = 1'b1;
      held_d  = 1'b1;
      cnt_d   = '0;
      state_d = HELD;
`ifdef KEY_REPEAT_EN
      rep_d   = '0;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= SCAN;
      row_q   <= '0;
      cand_q  <= '0;
      cnt_q   <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
`ifdef KEY_REPEAT_EN
      rep_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      held_q  <= held_d;
`ifdef KEY_REPEAT_EN
      rep_q   <= rep_d;
`endif
    end
  end

  assign keypad_row = ROW_IDLE & ~(ROWS'(1) << row_q);
  assign key_code   = code_q;
  assign key_valid  = valid_q;
  assign key_held   = held_q;

endmodule
